// File: rtl/irq_priority_ctrl.sv
// Interrupt priority controller.
// Rising-edge capture into a pending latch, per-channel mask, fixed-priority
// arbitration (highest index wins), nested preemption tracked by an in-service
// bitmap, and a registered request carrying the channel id and vector address.
module irq_priority_ctrl #(
    parameter int                N_IRQ      = 3,
    parameter int                WIDTH      = 32,
    parameter logic [WIDTH-1:0]  VEC_BASE   = 'h0000_0100,
    parameter int                VEC_STRIDE = 4,
    localparam int               ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ie,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [N_IRQ-1:0] irw,
    output logic [N_IRQ-1:0] pending
);

    // Registered state
    logic [N_IRQ-1:0] irq_d_q,   irq_d_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q,    mask_d;
    logic [N_IRQ-1:0] irw_q,     irw_d;
    logic             int_req_q, int_req_d;
    logic [ID_W-1:0]  int_id_q,  int_id_d;
    logic [WIDTH-1:0] int_vec_q, int_vec_d;

    // Combinational helpers
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] ack_sel;
    logic [N_IRQ-1:0] irw_after_ret;
    logic [ID_W-1:0]  top_p;
    logic [ID_W-1:0]  top_s;
    logic             any_p;
    logic             any_s;
    logic             want;
    logic             ack_fire;

    assign rise     = irq & ~irq_d_q;
    assign eligible = pending_q & ~mask_q;
    assign ack_fire = int_ack & int_req_q;

    // One-hot select of the channel being acknowledged this cycle
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_ack_sel
        assign ack_sel[gi] = ack_fire && (int_id_q == ID_W'(gi));
    end

    // Priority encoders: highest eligible request and highest in-service level
    always_comb begin
        top_p = '0;
        any_p = 1'b0;
        top_s = '0;
        any_s = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (eligible[i]) begin
                top_p = ID_W'(i);
                any_p = 1'b1;
            end
            if (irw_q[i]) begin
                top_s = ID_W'(i);
                any_s = 1'b1;
            end
        end
    end

    // A request only preempts strictly lower-priority service levels
    always_comb begin
        want = ie && any_p && (!any_s || (top_p > top_s));
    end

    // Next-state: pending/mask/in-service bookkeeping and the output register
    always_comb begin
        irq_d_d = irq;

        // A fresh edge beats the ack clear of the same channel
        pending_d = (pending_q & ~ack_sel) | rise;

        mask_d = mask_we ? mask_wdata : mask_q;

        // Return is applied first, then the ack marks its channel in service
        irw_after_ret = irw_q;
        if (int_ret && any_s) begin
            irw_after_ret[top_s] = 1'b0;
        end
        irw_d = irw_after_ret | ack_sel;

        // Hold request low for one cycle after a take to avoid a double take
        int_req_d = want && !ack_fire;
        int_id_d  = top_p;
        int_vec_d = VEC_BASE + WIDTH'(top_p) * WIDTH'(VEC_STRIDE);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_d_q   <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            irw_q     <= '0;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            int_vec_q <= '0;
        end else begin
            irq_d_q   <= irq_d_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irw_q     <= irw_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            int_vec_q <= int_vec_d;
        end
    end

    assign int_req = int_req_q;
    assign int_id  = int_id_q;
    assign int_vec = int_vec_q;
    assign irw     = irw_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Testbench for irq_priority_ctrl: directed scenarios on a 3-channel and an
// 8-channel instance, then randomized traffic against a reference model that
// tracks the in-service levels as a sorted list of channel numbers.
module tb_irq_priority_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 3-channel instance
    logic [2:0]  irq, mask_wdata, irw, pending;
    logic        mask_we, ie, int_ack, int_ret, int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;

    // 8-channel instance
    logic [7:0]  irq8, mask_wdata8, irw8, pending8;
    logic        mask_we8, ie8, int_ack8, int_ret8, int_req8;
    logic [2:0]  int_id8;
    logic [31:0] int_vec8;

    int cmp_count = 0;
    int err_count = 0;

    irq_priority_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ie(ie), .int_ack(int_ack), .int_ret(int_ret), .int_req(int_req), .int_id(int_id),
        .int_vec(int_vec), .irw(irw), .pending(pending)
    );

    irq_priority_ctrl #(.N_IRQ(8), .VEC_STRIDE(16)) dut8 (
        .clk(clk), .rst_n(rst_n), .irq(irq8), .mask_we(mask_we8), .mask_wdata(mask_wdata8),
        .ie(ie8), .int_ack(int_ack8), .int_ret(int_ret8), .int_req(int_req8), .int_id(int_id8),
        .int_vec(int_vec8), .irw(irw8), .pending(pending8)
    );

    // Reference model state for the 3-channel instance
    bit [2:0]    m_prev, m_pend, m_mask;
    int          m_stack[$];
    bit          m_req;
    int          m_id;
    logic [31:0] m_vec;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = '0;
        m_stack.delete();
        m_req = 1'b0; m_id = 0; m_vec = '0;
    endtask

    // In-service bitmap derived from the list of active levels
    function automatic bit [2:0] m_irw();
        bit [2:0] r = '0;
        foreach (m_stack[k]) r[m_stack[k]] = 1'b1;
        return r;
    endfunction

    // One clock of behaviour, computed from the inputs currently applied
    task automatic model_step();
        int  best = -1;
        int  top_s;
        bit  ack;
        bit  want;
        ack = int_ack && m_req;
        for (int i = 0; i < 3; i++) if (m_pend[i] && !m_mask[i]) best = i;
        top_s = (m_stack.size() > 0) ? m_stack[$] : -1;
        want = ie && (best >= 0) && (best > top_s);
        if (ack) m_pend[m_id] = 1'b0;
        for (int i = 0; i < 3; i++) if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
        if (int_ret && m_stack.size() > 0) void'(m_stack.pop_back());
        if (ack) begin m_stack.push_back(m_id); m_stack.sort(); end
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq;
        m_req = want && !ack;
        m_id  = (best < 0) ? 0 : best;
        m_vec = 32'h100 + 32'(m_id) * 4;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        if (!rst_n) model_reset(); else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL reset_req got=%0h exp=0", int_req); end
        cmp_count++; if (int_id !== 2'd0) begin err_count++; $display("FAIL reset_id got=%0h exp=0", int_id); end
        cmp_count++; if (int_vec !== 32'h0) begin err_count++; $display("FAIL reset_vec got=%0h exp=0", int_vec); end
        cmp_count++; if (irw !== 3'b000) begin err_count++; $display("FAIL reset_irw got=%b exp=000", irw); end
        cmp_count++; if (pending !== 3'b000) begin err_count++; $display("FAIL reset_pending got=%b exp=000", pending); end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        irq = 3'b010; tick();
        cmp_count++; if (pending !== 3'b010) begin err_count++; $display("FAIL basic_pending got=%b exp=010", pending); end
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL basic_req_early got=%0h exp=0", int_req); end
        irq = 3'b000; tick();
        cmp_count++; if (int_req !== 1'b1) begin err_count++; $display("FAIL basic_req got=%0h exp=1", int_req); end
        cmp_count++; if (int_id !== 2'd1) begin err_count++; $display("FAIL basic_id got=%0h exp=1", int_id); end
        cmp_count++; if (int_vec !== 32'h104) begin err_count++; $display("FAIL basic_vec got=%0h exp=104", int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        cmp_count++; if (irw !== 3'b010) begin err_count++; $display("FAIL basic_ack_irw got=%b exp=010", irw); end
        cmp_count++; if (pending !== 3'b000) begin err_count++; $display("FAIL basic_ack_pending got=%b exp=000", pending); end
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL basic_ack_req got=%0h exp=0", int_req); end
        int_ret = 1'b1; tick(); int_ret = 1'b0;
        cmp_count++; if (irw !== 3'b000) begin err_count++; $display("FAIL basic_ret_irw got=%b exp=000", irw); end
        tick();
        $display("test_basic done");
    endtask

    task automatic test_nesting();
        irq = 3'b010; tick(); irq = 3'b000; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 3'b100; tick(); irq = 3'b000; tick();
        cmp_count++; if (int_req !== 1'b1) begin err_count++; $display("FAIL nest_req2 got=%0h exp=1", int_req); end
        cmp_count++; if (int_id !== 2'd2) begin err_count++; $display("FAIL nest_id2 got=%0h exp=2", int_id); end
        cmp_count++; if (int_vec !== 32'h108) begin err_count++; $display("FAIL nest_vec2 got=%0h exp=108", int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        cmp_count++; if (irw !== 3'b110) begin err_count++; $display("FAIL nest_irw110 got=%b exp=110", irw); end
        irq = 3'b001; tick(); irq = 3'b000; tick(); tick();
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL nest_low_blocked got=%0h exp=0", int_req); end
        cmp_count++; if (pending !== 3'b001) begin err_count++; $display("FAIL nest_low_pending got=%b exp=001", pending); end
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        cmp_count++; if (irw !== 3'b010) begin err_count++; $display("FAIL nest_ret1_irw got=%b exp=010", irw); end
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL nest_ret1_req got=%0h exp=0", int_req); end
        int_ret = 1'b1; tick(); int_ret = 1'b0;
        cmp_count++; if (irw !== 3'b000) begin err_count++; $display("FAIL nest_ret2_irw got=%b exp=000", irw); end
        tick();
        cmp_count++; if (int_req !== 1'b1 || int_id !== 2'd0) begin err_count++; $display("FAIL nest_req0 got=%0h/%0h exp=1/0", int_req, int_id); end
        cmp_count++; if (int_vec !== 32'h100) begin err_count++; $display("FAIL nest_vec0 got=%0h exp=100", int_vec); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        $display("test_nesting done");
    endtask

    task automatic test_simultaneous();
        irq = 3'b101; tick(); irq = 3'b000; tick();
        cmp_count++; if (int_req !== 1'b1 || int_id !== 2'd2) begin err_count++; $display("FAIL simul_first got=%0h/%0h exp=1/2", int_req, int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        cmp_count++; if (irw !== 3'b100 || pending !== 3'b001) begin err_count++; $display("FAIL simul_ack got irw=%b pend=%b exp=100/001", irw, pending); end
        tick(); tick();
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL simul_wait got=%0h exp=0", int_req); end
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        cmp_count++; if (int_req !== 1'b1 || int_id !== 2'd0) begin err_count++; $display("FAIL simul_second got=%0h/%0h exp=1/0", int_req, int_id); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        $display("test_simultaneous done");
    endtask

    task automatic test_mask_enable();
        mask_we = 1'b1; mask_wdata = 3'b100; tick(); mask_we = 1'b0;
        irq = 3'b100; tick(); irq = 3'b000; tick(); tick();
        cmp_count++; if (pending !== 3'b100) begin err_count++; $display("FAIL mask_pending got=%b exp=100", pending); end
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL mask_blocked got=%0h exp=0", int_req); end
        mask_we = 1'b1; mask_wdata = 3'b000; tick(); mask_we = 1'b0; tick();
        cmp_count++; if (int_req !== 1'b1 || int_id !== 2'd2) begin err_count++; $display("FAIL unmask_req got=%0h/%0h exp=1/2", int_req, int_id); end
        ie = 1'b0; tick();
        cmp_count++; if (int_req !== 1'b0) begin err_count++; $display("FAIL ie_off_req got=%0h exp=0", int_req); end
        cmp_count++; if (pending !== 3'b100) begin err_count++; $display("FAIL ie_off_pending got=%b exp=100", pending); end
        ie = 1'b1; tick();
        cmp_count++; if (int_req !== 1'b1) begin err_count++; $display("FAIL ie_on_req got=%0h exp=1", int_req); end
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        cmp_count++; if (irw !== 3'b100) begin err_count++; $display("FAIL mask_ack_irw got=%b exp=100", irw); end
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        $display("test_mask_enable done");
    endtask

    task automatic test_corners();
        int  rises = 0;
        logic prev_req;
        irq = 3'b010;
        prev_req = int_req;
        for (int c = 0; c < 10; c++) begin
            int_ack = int_req;
            tick();
            if (int_req && !prev_req) rises++;
            prev_req = int_req;
        end
        int_ack = 1'b0; irq = 3'b000;
        cmp_count++; if (rises != 1) begin err_count++; $display("FAIL hold_one_req got=%0d exp=1", rises); end
        cmp_count++; if (irw !== 3'b010 || pending !== 3'b000) begin err_count++; $display("FAIL hold_state got irw=%b pend=%b exp=010/000", irw, pending); end
        int_ret = 1'b1; tick(); int_ret = 1'b0; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        cmp_count++; if (irw !== 3'b000 || pending !== 3'b000 || int_req !== 1'b0) begin err_count++; $display("FAIL stray_ack got irw=%b pend=%b req=%0h exp=000/000/0", irw, pending, int_req); end
        int_ret = 1'b1; tick(); int_ret = 1'b0;
        cmp_count++; if (irw !== 3'b000) begin err_count++; $display("FAIL stray_ret got=%b exp=000", irw); end
        // Build two nested levels plus a waiting lower request, then reset mid-cycle
        irq = 3'b010; tick(); irq = 3'b000; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 3'b100; tick(); irq = 3'b000; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        irq = 3'b010; tick(); irq = 3'b000; tick(); tick();
        cmp_count++; if (irw !== 3'b110 || pending !== 3'b010 || int_id !== 2'd1) begin err_count++; $display("FAIL prereset got irw=%b pend=%b id=%0h exp=110/010/1", irw, pending, int_id); end
        #3 rst_n = 1'b0;
        #1;
        cmp_count++; if (irw !== 3'b000 || pending !== 3'b000) begin err_count++; $display("FAIL async_rst_state got irw=%b pend=%b exp=000/000", irw, pending); end
        cmp_count++; if (int_req !== 1'b0 || int_id !== 2'd0 || int_vec !== 32'h0) begin err_count++; $display("FAIL async_rst_out got req=%0h id=%0h vec=%0h exp=0/0/0", int_req, int_id, int_vec); end
        tick();
        rst_n = 1'b1;
        tick();
        $display("test_corners done");
    endtask

    task automatic test_scale();
        irq8 = 8'h80; tick(); irq8 = 8'h00; tick();
        cmp_count++; if (int_req8 !== 1'b1 || int_id8 !== 3'd7) begin err_count++; $display("FAIL scale_req7 got=%0h/%0h exp=1/7", int_req8, int_id8); end
        cmp_count++; if (int_vec8 !== 32'h170) begin err_count++; $display("FAIL scale_vec7 got=%0h exp=170", int_vec8); end
        int_ack8 = 1'b1; tick(); int_ack8 = 1'b0;
        cmp_count++; if (irw8 !== 8'h80) begin err_count++; $display("FAIL scale_irw got=%0h exp=80", irw8); end
        irq8 = 8'h20; tick(); irq8 = 8'h00; tick(); tick();
        cmp_count++; if (int_req8 !== 1'b0 || pending8 !== 8'h20) begin err_count++; $display("FAIL scale_hold got req=%0h pend=%0h exp=0/20", int_req8, pending8); end
        int_ret8 = 1'b1; tick(); int_ret8 = 1'b0; tick();
        cmp_count++; if (int_req8 !== 1'b1 || int_id8 !== 3'd5) begin err_count++; $display("FAIL scale_req5 got=%0h/%0h exp=1/5", int_req8, int_id8); end
        cmp_count++; if (int_vec8 !== 32'h150) begin err_count++; $display("FAIL scale_vec5 got=%0h exp=150", int_vec8); end
        $display("test_scale done");
    endtask

    task automatic test_random();
        int shown = 0;
        int bad;
        rst_n = 1'b0; tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            irq        = irq ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            ie         = ($urandom_range(0, 19) != 0);
            int_ack    = ($urandom_range(0, 1) == 1);
            int_ret    = ($urandom_range(0, 5) == 0);
            tick();
            bad = 0;
            cmp_count++;
            if (int_req !== m_req || int_id !== 2'(m_id) || int_vec !== m_vec ||
                irw !== m_irw() || pending !== m_pend) begin
                err_count++;
                bad = 1;
            end
            if (bad != 0 && shown < 20) begin
                shown++;
                $display("FAIL random_cycle%0d got req=%0h id=%0h vec=%0h irw=%b pend=%b exp req=%0h id=%0h vec=%0h irw=%b pend=%b",
                         c, int_req, int_id, int_vec, irw, pending, m_req, 2'(m_id), m_vec, m_irw(), m_pend);
            end
        end
        irq = '0; mask_we = 1'b0; int_ack = 1'b0; int_ret = 1'b0; ie = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        irq = '0; mask_we = 1'b0; mask_wdata = '0; ie = 1'b1; int_ack = 1'b0; int_ret = 1'b0;
        irq8 = '0; mask_we8 = 1'b0; mask_wdata8 = '0; ie8 = 1'b1; int_ack8 = 1'b0; int_ret8 = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_nesting();
        test_simultaneous();
        test_mask_enable();
        test_corners();
        test_scale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
